or_share_arb: RTL and testbench

OR_SHARE_ARB -- requirements
Module: or_share_arb

---
 rtl/or_share_arb_if.sv | 39 +++
 rtl/or_share_arb.sv | 129 ++++++++++++
 tb/tb_or_share_arb.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/or_share_arb_if.sv
// Bus bundle between the requesters, the shared OR unit and or_share_arb.
// The err signal exists only when OR_ARB_CHK_EN is defined.
interface or_share_arb_if #(
  parameter int NREQ = 4,
  parameter int CNTW = 16
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] req_x;
  logic [NREQ-1:0] req_y;
  logic [NREQ-1:0] gnt;
  logic            or_x;
  logic            or_y;
  logic            or_z;
  logic [NREQ-1:0] rsp_valid;
  logic            rsp_z;
  logic            busy;
  logic [CNTW-1:0] txn_cnt;
`ifdef OR_ARB_CHK_EN
  logic            err;

  modport master (
    output req, req_x, req_y, or_z,
    input  gnt, or_x, or_y, rsp_valid, rsp_z, busy, txn_cnt, err
  );
  modport slave (
    input  req, req_x, req_y, or_z,
    output gnt, or_x, or_y, rsp_valid, rsp_z, busy, txn_cnt, err
  );
`else
  modport master (
    output req, req_x, req_y, or_z,
    input  gnt, or_x, or_y, rsp_valid, rsp_z, busy, txn_cnt
  );
  modport slave (
    input  req, req_x, req_y, or_z,
    output gnt, or_x, or_y, rsp_valid, rsp_z, busy, txn_cnt
  );
`endif
endinterface

// File: rtl/or_share_arb.sv
// Round-robin arbiter sharing one OR unit among NREQ requesters (grant, drive, respond).
// Optional result self-check with sticky err output when OR_ARB_CHK_EN is defined.
module or_share_arb #(
  parameter int NREQ = 4,
  parameter int CNTW = 16
) (
  input  logic         clk,
  input  logic         rst,
  or_share_arb_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [PW-1:0]   r_last_gnt;
  logic            r_or_x;
  logic            r_or_y;
  logic            r_rsp_z;
  logic [CNTW-1:0] r_txn_cnt;

  logic [PW-1:0]   w_cand [NREQ];
  logic [NREQ-1:0] w_hit;
  logic [PW-1:0]   w_win;
  logic            w_found;
  logic            w_take;

  // Candidate gi is the requester at offset gi+1 from the last grant, wrapped.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
      logic [PW:0] w_sum;
      assign w_sum         = {1'b0, r_last_gnt} + (PW+1)'(gi + 1);
      assign w_cand[gi]    = (w_sum >= (PW+1)'(NREQ)) ? PW'(w_sum - (PW+1)'(NREQ))
                                                      : w_sum[PW-1:0];
      assign w_hit[gi]     = bus.req[w_cand[gi]];
    end
  endgenerate

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_found = 1'b1;
        w_win   = w_cand[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_take       = 1'b1;
          w_state_next = DRIVE;
        end
      end
      DRIVE: w_state_next = RESP;
      RESP: begin
        if (w_found) begin
          w_take       = 1'b1;
          w_state_next = DRIVE;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
    // The grant is combinational, so it must be suppressed while reset is held.
    if (rst) begin
      w_take = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_gnt <= PW'(NREQ - 1);
      r_or_x     <= 1'b0;
      r_or_y     <= 1'b0;
      r_rsp_z    <= 1'b0;
      r_txn_cnt  <= '0;
    end else begin
      if (w_take) begin
        r_last_gnt <= w_win;
        r_or_x     <= bus.req_x[w_win];
        r_or_y     <= bus.req_y[w_win];
      end
      if (r_state == DRIVE) begin
        r_rsp_z <= bus.or_z;
      end
      if (r_state == RESP) begin
        r_txn_cnt <= r_txn_cnt + 1'b1;
      end
    end
  end

  assign bus.gnt       = w_take ? (NREQ'(1) << w_win) : '0;
  assign bus.rsp_valid = (r_state == RESP) ? (NREQ'(1) << r_last_gnt) : '0;
  assign bus.busy      = (r_state == DRIVE) || (r_state == RESP);
  assign bus.or_x      = r_or_x;
  assign bus.or_y      = r_or_y;
  assign bus.rsp_z     = r_rsp_z;
  assign bus.txn_cnt   = r_txn_cnt;

`ifdef OR_ARB_CHK_EN
  logic r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if ((r_state == DRIVE) && (bus.or_z != (r_or_x | r_or_y))) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`endif
endmodule

// File: tb/tb_or_share_arb.sv
// Directed and randomized bench for or_share_arb with a transaction-level reference model.
// Builds with or without OR_ARB_CHK_EN; uses CNTW=4 so counter wrap is reachable.
module tb_or_share_arb;
  localparam int NREQ   = 4;
  localparam int CNTW   = 4;
  localparam int CNTMOD = 1 << CNTW;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] rx;
  logic [NREQ-1:0] ry;
  logic            inject;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  or_share_arb_if #(.NREQ(NREQ), .CNTW(CNTW)) bus ();

  or_share_arb #(.NREQ(NREQ), .CNTW(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.req   = req;
  assign bus.req_x = rx;
  assign bus.req_y = ry;
  // Shared OR unit; inject forces a wrong result.
  assign bus.or_z  = inject ? 1'b0 : (bus.or_x | bus.or_y);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who was granted one and two cycles ago, pointer, operands, count.
  int   m_last, m_g1, m_g2, m_cnt;
  logic m_x, m_y, m_z, m_err;

  logic [NREQ-1:0] dut_gnt;
  int q_gnt[$];
  int q_cyc[$];
  int q_z[$];

  task automatic mreset();
    m_last = NREQ - 1;
    m_g1   = -1;
    m_g2   = -1;
    m_cnt  = 0;
    m_x    = 1'b0;
    m_y    = 1'b0;
    m_z    = 1'b0;
    m_err  = 1'b0;
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
    logic [NREQ-1:0] t;
    for (int k = 1; k <= NREQ; k++) begin
      t = r >> ((last + k) % NREQ);
      if (t[0]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic int first_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: check outputs mid-low-phase against the model, then advance the model.
  task automatic tick();
    int w;
    logic [NREQ-1:0] e_gnt, e_rv;
    logic e_busy;
    #2;
    if (rst) mreset();
    w      = (!rst && m_g1 < 0 && req != '0) ? rr_pick(req, m_last) : -1;
    e_gnt  = (w >= 0) ? (NREQ'(1) << w) : '0;
    e_rv   = (m_g2 >= 0) ? (NREQ'(1) << m_g2) : '0;
    e_busy = (m_g1 >= 0) || (m_g2 >= 0);
    dut_gnt = bus.gnt;
    chk("gnt",       32'(bus.gnt),       32'(e_gnt));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
    chk("busy",      32'(bus.busy),      32'(e_busy));
    chk("rsp_z",     32'(bus.rsp_z),     32'(m_z));
    chk("or_x",      32'(bus.or_x),      32'(m_x));
    chk("or_y",      32'(bus.or_y),      32'(m_y));
    chk("txn_cnt",   32'(bus.txn_cnt),   32'(m_cnt));
`ifdef OR_ARB_CHK_EN
    chk("err",       32'(bus.err),       32'(m_err));
`endif
    if (bus.gnt != '0) begin
      q_gnt.push_back(first_idx(bus.gnt));
      q_cyc.push_back(cyc);
    end
    if (bus.rsp_valid != '0) q_z.push_back(int'(bus.rsp_z));
    if (!rst) begin
      if (m_g2 >= 0) begin
        $display("txn requester=%0d z=%0d cnt_after=%0d", m_g2, m_z, (m_cnt + 1) % CNTMOD);
        m_cnt = (m_cnt + 1) % CNTMOD;
      end
      if (m_g1 >= 0) begin
        m_z = inject ? 1'b0 : (m_x | m_y);
        if (inject && (m_x | m_y)) m_err = 1'b1;
      end
      if (w >= 0) begin
        m_last = w;
        m_x    = rx[w];
        m_y    = ry[w];
      end
      m_g2 = m_g1;
      m_g1 = w;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic txn(input int r, input logic x, input logic y);
    req    = '0;
    req[r] = 1'b1;
    rx[r]  = x;
    ry[r]  = y;
    tick();
    req[r] = 1'b0;
    tick();
    tick();
  endtask

  task automatic clear_q();
    q_gnt.delete();
    q_cyc.delete();
    q_z.delete();
  endtask

  initial begin
    logic [NREQ-1:0] pairs_x;
    logic [NREQ-1:0] pairs_y;
    logic [NREQ-1:0] exp_z;
    int exp_order[5];
    rst    = 1'b1;
    req    = '0;
    rx     = '0;
    ry     = '0;
    inject = 1'b0;
    mreset();
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;

    // First grant right after reset, response two cycles later.
    clear_q();
    txn(0, 1'b1, 1'b0);
    chk("basic_gnt_cnt", 32'(q_gnt.size()), 32'd1);
    chk("basic_gnt_idx", 32'(q_gnt[0]), 32'd0);
    chk("basic_rsp_z",   32'(q_z[0]), 32'd1);
    chk("basic_txn_cnt", 32'(bus.txn_cnt), 32'd1);

    // All operand pairs through requester 2.
    clear_q();
    pairs_x = 4'b1100;
    pairs_y = 4'b1010;
    exp_z   = 4'b1110;
    for (int i = 0; i < 4; i++) txn(2, pairs_x[3 - i], pairs_y[3 - i]);
    chk("pairs_count", 32'(q_z.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("pairs_rsp_z", 32'(q_z[i]), 32'(exp_z[3 - i]));

    // All requesting, requester 0 re-requests after each response.
    do_reset();
    clear_q();
    exp_order = '{0, 1, 2, 3, 0};
    req = 4'hF;
    for (int c = 0; c < 10; c++) begin
      tick();
      req = req & ~dut_gnt;
      if (bus.rsp_valid[0]) req[0] = 1'b1;
    end
    req = '0;
    tick();
    tick();
    chk("rr_grants", 32'(q_gnt.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("rr_order", 32'(q_gnt[i]), 32'(exp_order[i]));
      if (i > 0) chk("rr_spacing", 32'(q_cyc[i] - q_cyc[i - 1]), 32'd2);
    end

    // Reset during DRIVE aborts the transaction; requester 0 wins first afterwards.
    clear_q();
    req = 4'b0100;
    rx  = 4'b0100;
    tick();
    req = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b0011;
    tick();
    chk("post_rst_gnt", 32'(dut_gnt), 32'd1);
    req = 4'b0010;
    tick();
    tick();
    req = '0;
    tick();
    tick();
    tick();
    chk("post_rst_rsp_count", 32'(q_z.size()), 32'd2);

    // Wrong OR result injected.
    do_reset();
    clear_q();
    inject = 1'b1;
    txn(0, 1'b1, 1'b0);
    inject = 1'b0;
    txn(1, 1'b0, 1'b0);
    chk("inject_rsp_z", 32'(q_z[0]), 32'd0);
`ifdef OR_ARB_CHK_EN
    chk("err_sticky", 32'(bus.err), 32'd1);
    do_reset();
    chk("err_cleared", 32'(bus.err), 32'd0);
`endif

    // Randomized traffic with withdrawals and re-requests.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i]) begin
          if ($urandom_range(3) == 0) begin
            req[i] = 1'b1;
            rx[i]  = 1'($urandom_range(1));
            ry[i]  = 1'($urandom_range(1));
          end
        end else if ($urandom_range(15) == 0) begin
          req[i] = 1'b0;
        end
      end
      inject = ($urandom_range(31) == 0);
      tick();
      req = req & ~dut_gnt;
    end
    req    = '0;
    inject = 1'b0;
    tick();
    tick();
    tick();

    // Counter wrap at 2^CNTW.
    do_reset();
    for (int i = 0; i < CNTMOD - 1; i++) txn(i % NREQ, 1'($urandom_range(1)), 1'($urandom_range(1)));
    chk("cnt_max", 32'(bus.txn_cnt), 32'(CNTMOD - 1));
    txn(3, 1'b0, 1'b1);
    chk("cnt_wrap", 32'(bus.txn_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
